// File: rtl/tdc_pulse_receiver_if.sv
// rtl/tdc_pulse_receiver_if.sv - result handshake bundle between tdc_pulse_receiver and its consumer
interface tdc_pulse_receiver_if #(
    parameter int CNT_W = 16
);
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] result_interval;
    logic             result_tag;

    modport master (
        output result_valid,
        output result_interval,
        output result_tag,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_interval,
        input  result_tag,
        output result_ready
    );
endinterface

// File: rtl/tdc_pulse_receiver.sv
// rtl/tdc_pulse_receiver.sv - start/stop strobe interval counter with tagged one-deep result register
module tdc_pulse_receiver #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_ref,
    input  logic                  sys_rstn,
    input  logic                  start_ext,
    input  logic                  stop_ext,
    input  logic                  err_clear,
    tdc_pulse_receiver_if.master  res,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  overrun_err
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [SYNC_STAGES-1:0] r_start_sync, r_stop_sync, r_sync_vld;
    logic                   r_start_prev, r_stop_prev;
    logic                   r_start_arm, r_stop_arm;
    logic                   r_start_edge, r_stop_edge;
    logic                   w_start_s, w_stop_s, w_sync_ok;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt, r_cap_interval, r_res_interval;
    logic                   r_cap_valid, r_cap_tag, r_tag, r_busy, r_timeout_err;
    logic                   r_res_valid, r_res_tag, r_overrun_err;

    assign w_start_s = r_start_sync[SYNC_STAGES-1];
    assign w_stop_s  = r_stop_sync[SYNC_STAGES-1];
    assign w_sync_ok = r_sync_vld[SYNC_STAGES-1];

    // r_sync_vld marks when the chain output reflects a real post-reset sample, so the
    // zeros left by reset cannot arm edge detection under a strobe that is already high.
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_start_sync <= '0;
            r_stop_sync  <= '0;
            r_sync_vld   <= '0;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
            r_start_arm  <= 1'b0;
            r_stop_arm   <= 1'b0;
            r_start_edge <= 1'b0;
            r_stop_edge  <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start_ext};
            r_stop_sync  <= {r_stop_sync[SYNC_STAGES-2:0], stop_ext};
            r_sync_vld   <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_start_prev <= w_start_s;
            r_stop_prev  <= w_stop_s;
            r_start_arm  <= r_start_arm | (w_sync_ok & ~w_start_s);
            r_stop_arm   <= r_stop_arm  | (w_sync_ok & ~w_stop_s);
            r_start_edge <= r_start_arm & w_start_s & ~r_start_prev;
            r_stop_edge  <= r_stop_arm  & w_stop_s  & ~r_stop_prev;
        end
    end

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_cap_valid    <= 1'b0;
            r_cap_interval <= '0;
            r_cap_tag      <= 1'b0;
            r_tag          <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_cap_valid <= 1'b0;
            if (err_clear) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_start_edge) begin
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    // A stop on the timeout cycle still completes the measurement.
                    if (r_stop_edge) begin
                        r_cap_valid    <= 1'b1;
                        r_cap_interval <= r_cnt;
                        r_cap_tag      <= r_tag;
                        r_tag          <= ~r_tag;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end else if (r_cnt == CNT_TMO) begin
                        r_timeout_err  <= 1'b1;
                        r_tag          <= ~r_tag;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_res_valid    <= 1'b0;
            r_res_interval <= '0;
            r_res_tag      <= 1'b0;
            r_overrun_err  <= 1'b0;
        end else begin
            if (err_clear) begin
                r_overrun_err <= 1'b0;
            end
            if (r_cap_valid) begin
                if (!r_res_valid || res.result_ready) begin
                    r_res_valid    <= 1'b1;
                    r_res_interval <= r_cap_interval;
                    r_res_tag      <= r_cap_tag;
                end else begin
                    r_overrun_err  <= 1'b1;
                end
            end else if (res.result_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res.result_valid    = r_res_valid;
    assign res.result_interval = r_res_interval;
    assign res.result_tag      = r_res_tag;
    assign busy                = r_busy;
    assign timeout_err         = r_timeout_err;
    assign overrun_err         = r_overrun_err;
endmodule

// File: tb/tb_tdc_pulse_receiver.sv
// tb/tb_tdc_pulse_receiver.sv - directed bench with a sample-time interval model for tdc_pulse_receiver
module tb_tdc_pulse_receiver;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 20;
    localparam int SYNC_STAGES = 2;

    logic clk_ref   = 1'b0;
    logic sys_rstn  = 1'b0;
    logic start_ext = 1'b0;
    logic stop_ext  = 1'b0;
    logic err_clear = 1'b0;
    logic busy, timeout_err, overrun_err;

    tdc_pulse_receiver_if #(.CNT_W(CNT_W)) res_if ();

    tdc_pulse_receiver #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_ref     (clk_ref),
        .sys_rstn    (sys_rstn),
        .start_ext   (start_ext),
        .stop_ext    (stop_ext),
        .err_clear   (err_clear),
        .res         (res_if),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #50 clk_ref = ~clk_ref;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: works on the strobe values sampled at each clock edge. A measurement
    // runs from the sample where start rose to the sample where stop rose; the
    // DUT shows busy/timeout 3 edges and the result register 4 edges after that.
    typedef struct packed {logic v; logic [CNT_W-1:0] k; logic tag;} res_t;
    int   m_n, m_s;
    bit   m_prev_st, m_prev_sp, m_active, m_tag;
    bit   busy_q[$], tmo_q[$];
    res_t res_q[$];
    logic exp_valid, exp_tag, exp_busy, exp_tmo, exp_ovr;
    logic [CNT_W-1:0] exp_int;
    int   model_last_k;
    bit   model_last_tag;

    task automatic m_reset();
        res_t z;
        z = '0;
        m_n = 0; m_s = 0;
        m_prev_st = 1'b1; m_prev_sp = 1'b1;
        m_active = 1'b0; m_tag = 1'b0;
        busy_q = {}; tmo_q = {}; res_q = {};
        repeat (3) begin busy_q.push_back(1'b0); tmo_q.push_back(1'b0); end
        repeat (4) res_q.push_back(z);
        exp_valid = 0; exp_tag = 0; exp_busy = 0; exp_tmo = 0; exp_ovr = 0; exp_int = '0;
    endtask

    initial begin
        bit st, sp, rdy, clr, rs, rp, tmo_now, b, t, ovr_evt;
        res_t r_now, r;
        m_reset();
        forever begin
            @(posedge clk_ref or negedge sys_rstn);
            if (!sys_rstn) begin
                m_reset();
            end else begin
                st = start_ext; sp = stop_ext; rdy = res_if.result_ready; clr = err_clear;
                rs = st && !m_prev_st;
                rp = sp && !m_prev_sp;
                m_prev_st = st; m_prev_sp = sp;
                r_now = '0; tmo_now = 0;
                if (m_active) begin
                    if (rp) begin
                        r_now.v = 1; r_now.k = CNT_W'(m_n - m_s); r_now.tag = m_tag;
                        model_last_k = m_n - m_s; model_last_tag = m_tag;
                        m_tag = !m_tag; m_active = 0;
                    end else if (m_n - m_s == TIMEOUT) begin
                        tmo_now = 1; m_tag = !m_tag; m_active = 0;
                    end
                end else if (rs) begin
                    m_active = 1; m_s = m_n;
                end
                busy_q.push_back(m_active); tmo_q.push_back(tmo_now); res_q.push_back(r_now);
                b = busy_q.pop_front(); t = tmo_q.pop_front(); r = res_q.pop_front();
                ovr_evt = 0;
                if (r.v) begin
                    if (!exp_valid || rdy) begin
                        exp_valid = 1; exp_int = r.k; exp_tag = r.tag;
                    end else begin
                        ovr_evt = 1;
                    end
                end else if (rdy) begin
                    exp_valid = 0;
                end
                exp_ovr  = ovr_evt | (exp_ovr & !clr);
                exp_tmo  = t | (exp_tmo & !clr);
                exp_busy = b;
                m_n++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_ref);
            chk("cyc_valid", res_if.result_valid, exp_valid);
            chk("cyc_busy", busy, exp_busy);
            chk("cyc_timeout", timeout_err, exp_tmo);
            chk("cyc_overrun", overrun_err, exp_ovr);
            if (exp_valid) begin
                chk("cyc_interval", res_if.result_interval, exp_int);
                chk("cyc_tag", res_if.result_tag, exp_tag);
            end
        end
    end

    // Handshake capture just before the edge that consumes the result.
    int hs_cnt = 0, valid_cycles = 0, last_int = -1, last_tag = -1;
    initial begin
        forever begin
            @(negedge clk_ref);
            #20;
            if (res_if.result_valid === 1'b1) valid_cycles++;
            if (res_if.result_valid === 1'b1 && res_if.result_ready === 1'b1) begin
                hs_cnt++;
                last_int = res_if.result_interval;
                last_tag = res_if.result_tag;
            end
        end
    end

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk_ref); #10; end
    endtask

    task automatic pair(input int k, input int stop_len);
        start_ext = 1'b1; step(k);
        start_ext = 1'b0; stop_ext = 1'b1; step(stop_len);
        stop_ext = 1'b0; step(12);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, res_if.result_valid, 0);
        chk({tag, "_interval"}, res_if.result_interval, 0);
        chk({tag, "_tag"}, res_if.result_tag, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout_err, 0);
        chk({tag, "_overrun"}, overrun_err, 0);
    endtask

    initial begin
        int e, h0, v0;
        res_if.result_ready = 1'b1;
        step(3);
        #20 sys_rstn = 1'b1;
        chk_all_zero("reset");
        step(2);

        // Back-to-back start/stop pairs, k=5, tags 0 then 1.
        h0 = hs_cnt; v0 = valid_cycles;
        pair(5, 5);
        chk("p1_interval", last_int, 5);
        chk("p1_tag", last_tag, 0);
        chk("p1_handshakes", hs_cnt - h0, 1);
        chk("p1_valid_cycles", valid_cycles - v0, 1);
        chk("p1_model_k", model_last_k, 5);
        h0 = hs_cnt;
        pair(5, 5);
        chk("p2_interval", last_int, 5);
        chk("p2_tag", last_tag, 1);
        chk("p2_handshakes", hs_cnt - h0, 1);

        // Start and stop rise together; stop re-rises 6 cycles after the start.
        h0 = hs_cnt;
        start_ext = 1'b1; stop_ext = 1'b1; step(3);
        stop_ext = 1'b0; step(3);
        stop_ext = 1'b1; step(3);
        start_ext = 1'b0; stop_ext = 1'b0; step(12);
        chk("simul_interval", last_int, 6);
        chk("simul_tag", last_tag, 0);
        chk("simul_handshakes", hs_cnt - h0, 1);
        chk("simul_model_k", model_last_k, 6);

        // Start with no stop: timeout TIMEOUT+3 edges after the start sample.
        h0 = hs_cnt;
        start_ext = 1'b1; e = m_n; step(1);
        start_ext = 1'b0;
        while (m_n < e + TIMEOUT + 3) step(1);
        chk("tmo_before", timeout_err, 0);
        chk("tmo_busy_before", busy, 1);
        step(1);
        chk("tmo_after", timeout_err, 1);
        chk("tmo_busy_after", busy, 0);
        step(5);
        chk("tmo_no_result", hs_cnt - h0, 0);
        pair(7, 3);
        chk("post_tmo_interval", last_int, 7);
        chk("post_tmo_tag", last_tag, 0);

        // Consumer stalled: second result is dropped.
        res_if.result_ready = 1'b0;
        h0 = hs_cnt;
        pair(4, 3);
        pair(9, 3);
        chk("ovr_valid", res_if.result_valid, 1);
        chk("ovr_interval", res_if.result_interval, 4);
        chk("ovr_tag", res_if.result_tag, 1);
        chk("ovr_flag", overrun_err, 1);
        chk("ovr_handshakes", hs_cnt - h0, 0);
        chk("ovr_model_k", model_last_k, 9);
        res_if.result_ready = 1'b1; step(1);
        chk("ovr_drain_valid", res_if.result_valid, 0);
        err_clear = 1'b1; step(1);
        err_clear = 1'b0;
        chk("clr_overrun", overrun_err, 0);
        chk("clr_timeout", timeout_err, 0);

        // Start held high through reset release must not open a measurement.
        #20 sys_rstn = 1'b0;
        start_ext = 1'b1;
        step(2);
        #20 sys_rstn = 1'b1;
        h0 = hs_cnt;
        step(8);
        chk("held_busy", busy, 0);
        chk("held_no_result", hs_cnt - h0, 0);
        start_ext = 1'b0; step(2);
        pair(3, 3);
        chk("held_interval", last_int, 3);
        chk("held_tag", last_tag, 0);
        chk("held_handshakes", hs_cnt - h0, 1);

        // Asynchronous reset in the middle of a measurement.
        start_ext = 1'b1; step(2);
        start_ext = 1'b0; step(3);
        chk("midrun_busy", busy, 1);
        #20 sys_rstn = 1'b0;
        #1 chk_all_zero("midrun_reset");
        step(1);
        #20 sys_rstn = 1'b1;
        h0 = hs_cnt;
        stop_ext = 1'b1; step(3);
        stop_ext = 1'b0; step(12);
        chk("stop_alone_handshakes", hs_cnt - h0, 0);
        chk("stop_alone_valid", res_if.result_valid, 0);
        chk("stop_alone_busy", busy, 0);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
